// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory_access arbiter.
package mem_arb_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // Width of the memory_access CTRL field
  localparam int MA_CTRL_W = 3;

  // Minimum number of cycles spent with ENABLE low after a completion
  localparam int RELEASE_MIN = 2;

  // Requester identifier: 0 = pipeline memory stage, 1 = convolution prefetch
  typedef logic [0:0] req_id_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Combinational two-way round-robin picker: on a tie the port that was
// not served last wins, otherwise the single requester is chosen.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_id,
  output logic       grant_valid,
  output req_id_t    grant_id
);

  // Pick the winner from the current request pattern and the last-served port
  always_comb begin
    grant_valid = |req;
    grant_id    = req_id_t'(0);
    if (req == 2'b11) begin
      grant_id = ~last_id;
    end else if (req[1]) begin
      grant_id = req_id_t'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory_access unit between the
// pipeline memory stage (port 0) and the convolution prefetch engine (port 1).
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort an ISSUE that sees no
// handshake within TIMEOUT_CYCLES cycles (DONE and ERR pulse together, RDATA=0).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 48,
  parameter int DATA_W         = 48,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic [MA_CTRL_W-1:0] CTRL0,
  input  logic [MA_CTRL_W-1:0] CTRL1,
  input  logic [ADDR_W-1:0]    ADDR0,
  input  logic [ADDR_W-1:0]    ADDR1,
  output logic                 DONE0,
  output logic                 DONE1,
  output logic                 ERR0,
  output logic                 ERR1,
  output logic [DATA_W-1:0]    RDATA0,
  output logic [DATA_W-1:0]    RDATA1,
  output logic                 MA_ENABLE,
  output logic [MA_CTRL_W-1:0] MA_CTRL,
  output logic [ADDR_W-1:0]    MA_ADDRESS,
  input  logic [DATA_W-1:0]    MA_READ,
  input  logic                 MA_HANDSHAKE,
  output logic                 BUSY
);

  arb_state_t           state, state_next;
  req_id_t              grant_id, grant_id_next;
  req_id_t              last_id, last_id_next;
  logic [1:0]           rel_cnt, rel_cnt_next;
  logic                 ma_enable_next;
  logic [MA_CTRL_W-1:0] ma_ctrl_next;
  logic [ADDR_W-1:0]    ma_address_next;
  logic                 done0_next, done1_next, err0_next, err1_next;
  logic [DATA_W-1:0]    rdata0_next, rdata1_next;
  logic                 busy_next;
  logic                 finish;
  logic                 finish_err;
  logic [DATA_W-1:0]    finish_data;
  logic                 pick_valid;
  req_id_t              pick_id;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]     cnt, cnt_next;
`endif

  mem_arb_rr2 u_rr2 (
    .req         ({REQ1, REQ0}),
    .last_id     (last_id),
    .grant_valid (pick_valid),
    .grant_id    (pick_id)
  );

  // Next-state and next-output logic; every register value is computed here
  always_comb begin
    state_next      = state;
    grant_id_next   = grant_id;
    last_id_next    = last_id;
    rel_cnt_next    = rel_cnt;
    ma_enable_next  = 1'b0;
    ma_ctrl_next    = MA_CTRL;
    ma_address_next = MA_ADDRESS;
    done0_next      = 1'b0;
    done1_next      = 1'b0;
    err0_next       = 1'b0;
    err1_next       = 1'b0;
    rdata0_next     = RDATA0;
    rdata1_next     = RDATA1;
    finish          = 1'b0;
    finish_err      = 1'b0;
    finish_data     = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_next        = cnt;
`endif

    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_id_next   = pick_id;
          ma_ctrl_next    = (pick_id == req_id_t'(1)) ? CTRL1 : CTRL0;
          ma_address_next = (pick_id == req_id_t'(1)) ? ADDR1 : ADDR0;
          ma_enable_next  = 1'b1;
          state_next      = ST_ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_next        = '0;
`endif
        end
      end
      ST_ISSUE: begin
        ma_enable_next = 1'b1;
        if (MA_HANDSHAKE) begin
          finish      = 1'b1;
          finish_data = MA_READ;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
`endif
      end
      ST_RELEASE: begin
        if ((rel_cnt >= 2'(RELEASE_MIN - 1)) && !MA_HANDSHAKE) begin
          state_next = ST_IDLE;
        end else if (rel_cnt < 2'(RELEASE_MIN - 1)) begin
          rel_cnt_next = rel_cnt + 2'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (finish) begin
      state_next     = ST_RELEASE;
      ma_enable_next = 1'b0;
      rel_cnt_next   = 2'd0;
      last_id_next   = grant_id;
      if (grant_id == req_id_t'(1)) begin
        rdata1_next = finish_data;
        done1_next  = 1'b1;
        err1_next   = finish_err;
      end else begin
        rdata0_next = finish_data;
        done0_next  = 1'b1;
        err0_next   = finish_err;
      end
    end

    busy_next = (state_next != ST_IDLE);
  end

  // State and output registers; reset drops ENABLE immediately and aborts any access
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      grant_id   <= req_id_t'(0);
      last_id    <= req_id_t'(1);
      rel_cnt    <= 2'd0;
      MA_ENABLE  <= 1'b0;
      MA_CTRL    <= '0;
      MA_ADDRESS <= '0;
      DONE0      <= 1'b0;
      DONE1      <= 1'b0;
      ERR0       <= 1'b0;
      ERR1       <= 1'b0;
      RDATA0     <= '0;
      RDATA1     <= '0;
      BUSY       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      state      <= state_next;
      grant_id   <= grant_id_next;
      last_id    <= last_id_next;
      rel_cnt    <= rel_cnt_next;
      MA_ENABLE  <= ma_enable_next;
      MA_CTRL    <= ma_ctrl_next;
      MA_ADDRESS <= ma_address_next;
      DONE0      <= done0_next;
      DONE1      <= done1_next;
      ERR0       <= err0_next;
      ERR1       <= err1_next;
      RDATA0     <= rdata0_next;
      RDATA1     <= rdata1_next;
      BUSY       <= busy_next;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt        <= cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory_access model.
// The watchdog scenario follows MEM_ARB_TIMEOUT_EN in the same way as the design.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 48;
  localparam int DATA_W = 48;

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic                 REQ0, REQ1;
  logic [MA_CTRL_W-1:0] CTRL0, CTRL1;
  logic [ADDR_W-1:0]    ADDR0, ADDR1;
  logic                 DONE0, DONE1, ERR0, ERR1;
  logic [DATA_W-1:0]    RDATA0, RDATA1;
  logic                 MA_ENABLE;
  logic [MA_CTRL_W-1:0] MA_CTRL;
  logic [ADDR_W-1:0]    MA_ADDRESS;
  logic [DATA_W-1:0]    MA_READ;
  logic                 MA_HANDSHAKE;
  logic                 BUSY;

  int checks = 0;
  int errors = 0;

  bit                model_on = 1'b0;
  bit                use_fn = 1'b0;
  int                hs_delay = 5;
  int                hs_hold = 0;
  logic [DATA_W-1:0] fixed_read = '0;
  int                lat_cnt = 0;
  int                hold_cnt = 0;

  mem_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .REQ0         (REQ0),
    .REQ1         (REQ1),
    .CTRL0        (CTRL0),
    .CTRL1        (CTRL1),
    .ADDR0        (ADDR0),
    .ADDR1        (ADDR1),
    .DONE0        (DONE0),
    .DONE1        (DONE1),
    .ERR0         (ERR0),
    .ERR1         (ERR1),
    .RDATA0       (RDATA0),
    .RDATA1       (RDATA1),
    .MA_ENABLE    (MA_ENABLE),
    .MA_CTRL      (MA_CTRL),
    .MA_ADDRESS   (MA_ADDRESS),
    .MA_READ      (MA_READ),
    .MA_HANDSHAKE (MA_HANDSHAKE),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    return a ^ 48'h5555_AAAA_0F0F;
  endfunction

  // memory_access model: raise HANDSHAKE hs_delay cycles into ENABLE, hold it hs_hold cycles after ENABLE drops
  initial begin
    MA_HANDSHAKE = 1'b0;
    MA_READ      = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (!model_on) begin
        MA_HANDSHAKE = 1'b0;
        lat_cnt      = 0;
        hold_cnt     = 0;
      end else if (MA_ENABLE && !MA_HANDSHAKE) begin
        if (lat_cnt >= hs_delay - 1) begin
          MA_HANDSHAKE = 1'b1;
          MA_READ      = use_fn ? mem_fn(MA_ADDRESS) : fixed_read;
          lat_cnt      = 0;
        end else begin
          lat_cnt++;
        end
      end else if (!MA_ENABLE && MA_HANDSHAKE) begin
        if (hold_cnt >= hs_hold) begin
          MA_HANDSHAKE = 1'b0;
          hold_cnt     = 0;
        end else begin
          hold_cnt++;
        end
      end
    end
  end

  // Global time limit so the run always ends
  initial begin
    #300000;
    $display("[TB] FAIL global_timeout simulation did not finish, required finish before 300us");
    $fatal(1, "[TB] time limit");
  end

  task automatic do_reset();
    model_on = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY !== 1'b0 && n < 30) begin
      @(negedge CLK); n++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    CTRL0 = '0; CTRL1 = '0; ADDR0 = '0; ADDR1 = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if (MA_ENABLE !== 1'b0 || MA_CTRL !== 3'b000 || MA_ADDRESS !== 48'h0 || BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ma en=%b ctrl=%b addr=%h busy=%b, required all zero", MA_ENABLE, MA_CTRL, MA_ADDRESS, BUSY);
    end
    checks++;
    if (DONE0 !== 1'b0 || DONE1 !== 1'b0 || ERR0 !== 1'b0 || ERR1 !== 1'b0 || RDATA0 !== 48'h0 || RDATA1 !== 48'h0) begin
      errors++;
      $display("[TB] FAIL reset_ports done=%b%b err=%b%b rdata0=%h rdata1=%h, required all zero", DONE1, DONE0, ERR1, ERR0, RDATA0, RDATA1);
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single();
    int  n;
    bit  seen;
    do_reset();
    model_on = 1'b1; use_fn = 1'b0; fixed_read = 48'hABCD; hs_delay = 5; hs_hold = 0;
    @(negedge CLK);
    ADDR0 = 48'h10; CTRL0 = 3'b000; REQ0 = 1'b1;
    @(negedge CLK);
    checks++;
    if (MA_ENABLE !== 1'b1 || BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_grant en=%b busy=%b, required 1 1", MA_ENABLE, BUSY);
    end
    checks++;
    if (MA_ADDRESS !== 48'h10 || MA_CTRL !== 3'b000) begin
      errors++;
      $display("[TB] FAIL single_addr addr=%h ctrl=%b, required 10 000", MA_ADDRESS, MA_CTRL);
    end
    seen = 1'b0; n = 0;
    while (!seen && n < 50) begin
      @(negedge CLK); n++;
      if (DONE0 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL single_done DONE0 not seen in %0d cycles, required a pulse", n);
    end
    checks++;
    if (RDATA0 !== 48'hABCD || ERR0 !== 1'b0 || DONE1 !== 1'b0 || MA_ENABLE !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_data rdata0=%h err0=%b done1=%b en=%b, required abcd 0 0 0", RDATA0, ERR0, DONE1, MA_ENABLE);
    end
    REQ0 = 1'b0;
    @(negedge CLK);
    checks++;
    if (DONE0 !== 1'b0 || RDATA0 !== 48'hABCD) begin
      errors++;
      $display("[TB] FAIL single_pulse done0=%b rdata0=%h, required 0 abcd", DONE0, RDATA0);
    end
    wait_idle();
  endtask

  task automatic test_round_robin();
    int n, got0, got1, grant_k, act_port;
    logic [DATA_W-1:0] exp_data, act_data;
    do_reset();
    model_on = 1'b1; use_fn = 1'b1; hs_delay = 3; hs_hold = 0;
    grant_k = 0;
    for (int it = 0; it < 4; it++) begin
      @(negedge CLK);
      ADDR0 = 48'h100 + 48'(it); ADDR1 = 48'h200 + 48'(it);
      CTRL0 = 3'b001; CTRL1 = 3'b000;
      REQ0 = 1'b1; REQ1 = 1'b1;
      got0 = 0; got1 = 0; n = 0;
      while ((got0 + got1) < 2 && n < 100) begin
        @(negedge CLK); n++;
        if (DONE0 === 1'b1 || DONE1 === 1'b1) begin
          act_port = (DONE1 === 1'b1) ? 1 : 0;
          checks++;
          if ((DONE0 === 1'b1 && DONE1 === 1'b1) || act_port != (grant_k % 2)) begin
            errors++;
            $display("[TB] FAIL rr_order grant %0d done=%b%b, required port %0d", grant_k, DONE1, DONE0, grant_k % 2);
          end
          exp_data = (act_port == 1) ? mem_fn(ADDR1) : mem_fn(ADDR0);
          act_data = (act_port == 1) ? RDATA1 : RDATA0;
          checks++;
          if (act_data !== exp_data) begin
            errors++;
            $display("[TB] FAIL rr_data port %0d rdata=%h, required %h", act_port, act_data, exp_data);
          end
          if (act_port == 1) begin
            got1++; REQ1 = 1'b0;
          end else begin
            got0++; REQ0 = 1'b0;
          end
          grant_k++;
        end
      end
      checks++;
      if (got0 != 1 || got1 != 1) begin
        errors++;
        $display("[TB] FAIL rr_count iter %0d done0 x%0d done1 x%0d, required 1 each", it, got0, got1);
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    wait_idle();
  endtask

  task automatic test_handshake_hold();
    int n, bad, gap;
    bit seen;
    model_on = 1'b1; use_fn = 1'b0; fixed_read = 48'h1234; hs_delay = 2; hs_hold = 4;
    @(negedge CLK);
    ADDR0 = 48'h40; ADDR1 = 48'h50; REQ0 = 1'b1; REQ1 = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(negedge CLK); n++;
      if (DONE0 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL hold_first DONE0 not seen in %0d cycles, required a pulse", n);
    end
    REQ0 = 1'b0;
    bad = 0; n = 0;
    while (MA_HANDSHAKE === 1'b1 && n < 20) begin
      if (MA_ENABLE !== 1'b0 || BUSY !== 1'b1) bad++;
      @(negedge CLK); n++;
    end
    checks++;
    if (bad != 0 || MA_ENABLE !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release %0d cycles with enable/busy wrong, en=%b after drop, required 0 and en 0", bad, MA_ENABLE);
    end
    gap = 0;
    while (MA_ENABLE !== 1'b1 && gap < 10) begin
      @(negedge CLK); gap++;
    end
    checks++;
    if (gap != 2 || MA_ADDRESS !== 48'h50) begin
      errors++;
      $display("[TB] FAIL hold_regrant gap=%0d addr=%h, required 2 and 50", gap, MA_ADDRESS);
    end
    hs_hold = 0;
    seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(negedge CLK); n++;
      if (DONE1 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || RDATA1 !== 48'h1234) begin
      errors++;
      $display("[TB] FAIL hold_second seen=%b rdata1=%h, required 1 1234", seen, RDATA1);
    end
    REQ1 = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_in_issue();
    int n, bad;
    bit seen;
    // Serve port 0 alone first so the pointer points at port 0 before the reset
    model_on = 1'b1; use_fn = 1'b0; fixed_read = 48'h77; hs_delay = 2; hs_hold = 0;
    @(negedge CLK);
    ADDR0 = 48'h70; REQ0 = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(negedge CLK); n++;
      if (DONE0 === 1'b1) seen = 1'b1;
    end
    REQ0 = 1'b0;
    wait_idle();
    model_on = 1'b0;
    @(negedge CLK);
    ADDR1 = 48'h77; REQ1 = 1'b1;
    @(negedge CLK);
    checks++;
    if (MA_ENABLE !== 1'b1 || BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_issue_pre en=%b busy=%b, required 1 1", MA_ENABLE, BUSY);
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (MA_ENABLE !== 1'b0 || BUSY !== 1'b0 || DONE1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_issue_async en=%b busy=%b done1=%b, required 0 0 0", MA_ENABLE, BUSY, DONE1);
    end
    REQ1 = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge CLK);
      if (DONE1 !== 1'b0 || DONE0 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL rst_issue_nodone %0d cycles with DONE high, required 0", bad);
    end
    ADDR0 = 48'h88; ADDR1 = 48'h99; REQ0 = 1'b1; REQ1 = 1'b1;
    @(negedge CLK);
    checks++;
    if (MA_ENABLE !== 1'b1 || MA_ADDRESS !== 48'h88) begin
      errors++;
      $display("[TB] FAIL rst_issue_ptr en=%b addr=%h, required 1 88 (port 0 wins tie)", MA_ENABLE, MA_ADDRESS);
    end
    do_reset();
  endtask

  task automatic test_addr_hold();
    int n, bad;
    bit seen;
    do_reset();
    model_on = 1'b1; use_fn = 1'b0; fixed_read = 48'hC0FFEE; hs_delay = 6; hs_hold = 0;
    @(negedge CLK);
    ADDR1 = 48'h20; CTRL1 = 3'b010; REQ1 = 1'b1;
    @(negedge CLK);
    checks++;
    if (MA_ENABLE !== 1'b1 || MA_ADDRESS !== 48'h20 || MA_CTRL !== 3'b010) begin
      errors++;
      $display("[TB] FAIL addr_grant en=%b addr=%h ctrl=%b, required 1 20 010", MA_ENABLE, MA_ADDRESS, MA_CTRL);
    end
    ADDR1 = 48'h30; CTRL1 = 3'b111;
    seen = 1'b0; n = 0; bad = 0;
    while (!seen && n < 40) begin
      @(negedge CLK); n++;
      if (MA_ADDRESS !== 48'h20 || MA_CTRL !== 3'b010) bad++;
      if (DONE1 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL addr_hold %0d cycles with addr/ctrl changed (addr=%h), required 20 held", bad, MA_ADDRESS);
    end
    checks++;
    if (!seen || RDATA1 !== 48'hC0FFEE) begin
      errors++;
      $display("[TB] FAIL addr_done seen=%b rdata1=%h, required 1 c0ffee", seen, RDATA1);
    end
    REQ1 = 1'b0;
    wait_idle();
  endtask

  task automatic test_timeout();
    int n, bad;
    bit seen;
    model_on = 1'b0;
    @(negedge CLK);
    ADDR1 = 48'h60; REQ1 = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
    seen = 1'b0; n = 0; bad = 0;
    while (!seen && n < 40) begin
      @(negedge CLK); n++;
      if (DONE1 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 17) begin
      errors++;
      $display("[TB] FAIL timeout_cycle seen=%b at ISSUE cycle %0d, required 1 at 17", seen, n);
    end
    checks++;
    if (ERR1 !== 1'b1 || RDATA1 !== 48'h0 || DONE0 !== 1'b0 || ERR0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_flags err1=%b rdata1=%h done0=%b err0=%b, required 1 0 0 0", ERR1, RDATA1, DONE0, ERR0);
    end
    REQ1 = 1'b0;
    @(negedge CLK);
    checks++;
    if (ERR1 !== 1'b0 || DONE1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_pulse err1=%b done1=%b, required 0 0", ERR1, DONE1);
    end
`else
    seen = 1'b0; n = 0; bad = 0;
    repeat (100) begin
      @(negedge CLK); n++;
      if (DONE1 !== 1'b0 || ERR1 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || MA_ENABLE !== 1'b1) begin
      errors++;
      $display("[TB] FAIL no_timeout %0d cycles with DONE1/ERR1 high, en=%b, required 0 and en 1", bad, MA_ENABLE);
    end
`endif
    do_reset();
  endtask

  // Scenario sequence
  initial begin
    RESET = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    CTRL0 = '0; CTRL1 = '0; ADDR0 = '0; ADDR1 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_handshake_hold();
    test_reset_in_issue();
    test_addr_hold();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
